ysyx_25040129_csr_seq: RTL and testbench

//  Multi-cycle CSR/trap sequencer between the EXU and the CSR register file.
//  It executes CSRRW/CSRRS/CSRRC read-modify-write, ECALL entry and MRET return.
//  It owns the CSR file's single read port and single write port, so no other block drives them.
//  It returns rd data to the EXU, or a PC redirect for traps.

---
 rtl/ysyx_25040129_csr_seq_pkg.sv | 47 ++++
 rtl/ysyx_25040129_csr_seq_alu.sv | 35 +++
 rtl/ysyx_25040129_csr_seq.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_25040129_csr_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_csr_seq_pkg.sv
// Shared definitions for the CSR/trap sequencer: op codes, CSR addresses,
// mstatus bit positions, sequencer states and CSR ALU function codes.
package ysyx_25040129_csr_seq_pkg;

    localparam int CSR_DIG_W = 12;
    localparam int XLEN_W    = 32;

    // EXU request op encodings; every other value is illegal
    localparam logic [2:0] OP_RW    = 3'b000;
    localparam logic [2:0] OP_RS    = 3'b001;
    localparam logic [2:0] OP_RC    = 3'b010;
    localparam logic [2:0] OP_ECALL = 3'b011;
    localparam logic [2:0] OP_MRET  = 3'b100;

    // Machine-mode CSR addresses touched by the trap sequences
    localparam logic [CSR_DIG_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_DIG_W-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_DIG_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_DIG_W-1:0] CSR_MCAUSE  = 12'h342;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        FN_RW   = 3'd0,
        FN_RS   = 3'd1,
        FN_RC   = 3'd2,
        FN_TRAP = 3'd3,
        FN_RET  = 3'd4,
        FN_PASS = 3'd5
    } alu_fn_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RMW    = 3'd1,
        ST_E_EPC  = 3'd2,
        ST_E_STAT = 3'd3,
        ST_E_VEC  = 3'd4,
        ST_R_EPC  = 3'd5,
        ST_R_STAT = 3'd6,
        ST_RESP   = 3'd7
    } state_t;

endpackage

// File: rtl/ysyx_25040129_csr_seq_alu.sv
// Combinational CSR data path: RW/RS/RC results and the mstatus
// transforms applied on trap entry (ECALL) and trap return (MRET).
module ysyx_25040129_csr_alu
    import ysyx_25040129_csr_seq_pkg::*;
#(
    parameter int XLEN = XLEN_W
) (
    input  alu_fn_t         fn,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] result
);

    // Select the new CSR value for the requested function
    always_comb begin
        result = old;
        case (fn)
            FN_RW: result = src;
            FN_RS: result = old | src;
            FN_RC: result = old & ~src;
            FN_TRAP: begin
                result[MSTATUS_MPIE]                  = old[MSTATUS_MIE];
                result[MSTATUS_MIE]                   = 1'b0;
                result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            FN_RET: begin
                result[MSTATUS_MIE]                   = old[MSTATUS_MPIE];
                result[MSTATUS_MPIE]                  = 1'b1;
                result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            default: result = old;
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_csr_seq.sv
// Multi-cycle CSR/trap sequencer. Sole owner of the CSR file read and
// write ports; every output is registered. A read address is presented
// in the state that consumes csr_out, and each write step is registered
// at the end of its state, so csr_data/csr_write_addr are stable for the
// whole single-cycle csr_write pulse.
module ysyx_25040129_csr_seq
    import ysyx_25040129_csr_seq_pkg::*;
#(
    parameter int CSR_DIG = CSR_DIG_W,
    parameter int XLEN    = XLEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [CSR_DIG-1:0] in_addr,
    input  logic [XLEN-1:0]    in_src,
    input  logic               in_src_is_x0,
    input  logic [XLEN-1:0]    in_pc,
    output logic [CSR_DIG-1:0] csr_read_addr,
    input  logic [XLEN-1:0]    csr_out,
    output logic               csr_write,
    output logic [CSR_DIG-1:0] csr_write_addr,
    output logic [XLEN-1:0]    csr_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_rd,
    output logic               out_redirect,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_err
);

    state_t             state;
    logic [2:0]         op_r;
    logic [CSR_DIG-1:0] addr_r;
    logic [XLEN-1:0]    src_r;
    logic               x0_r;
    logic [XLEN-1:0]    pc_r;
    alu_fn_t            alu_fn;
    logic [XLEN-1:0]    alu_result;
    logic               rmw_writes;

    ysyx_25040129_csr_alu #(.XLEN(XLEN)) u_alu (
        .fn     (alu_fn),
        .old    (csr_out),
        .src    (src_r),
        .result (alu_result)
    );

    // RS/RC with a zero source are pure reads; RW always writes
    assign rmw_writes = (op_r == OP_RW) || !x0_r;

    // Pick the ALU function from the state that owns the write step
    always_comb begin
        alu_fn = FN_PASS;
        case (state)
            ST_RMW: begin
                case (op_r)
                    OP_RS:   alu_fn = FN_RS;
                    OP_RC:   alu_fn = FN_RC;
                    default: alu_fn = FN_RW;
                endcase
            end
            ST_E_STAT: alu_fn = FN_TRAP;
            ST_R_STAT: alu_fn = FN_RET;
            default:   alu_fn = FN_PASS;
        endcase
    end

    // Sequencer FSM with registered CSR-port and EXU-response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_r           <= 3'b000;
            addr_r         <= '0;
            src_r          <= '0;
            x0_r           <= 1'b0;
            pc_r           <= '0;
            in_ready       <= 1'b1;
            csr_read_addr  <= '0;
            csr_write      <= 1'b0;
            csr_write_addr <= '0;
            csr_data       <= '0;
            out_valid      <= 1'b0;
            out_rd         <= '0;
            out_redirect   <= 1'b0;
            out_pc         <= '0;
            out_err        <= 1'b0;
        end else begin
            csr_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_r         <= in_op;
                        addr_r       <= in_addr;
                        src_r        <= in_src;
                        x0_r         <= in_src_is_x0;
                        pc_r         <= in_pc;
                        in_ready     <= 1'b0;
                        out_rd       <= '0;
                        out_pc       <= '0;
                        out_redirect <= 1'b0;
                        out_err      <= 1'b0;
                        case (in_op)
                            OP_RW, OP_RS, OP_RC: begin
                                state         <= ST_RMW;
                                csr_read_addr <= in_addr;
                            end
                            OP_ECALL: begin
                                state         <= ST_E_EPC;
                                csr_read_addr <= '0;
                            end
                            OP_MRET: begin
                                state         <= ST_R_EPC;
                                csr_read_addr <= CSR_DIG'(CSR_MEPC);
                            end
                            default: begin
                                state         <= ST_RESP;
                                csr_read_addr <= '0;
                                out_valid     <= 1'b1;
                                out_err       <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RMW: begin
                    out_rd         <= csr_out;
                    csr_write      <= rmw_writes;
                    csr_write_addr <= addr_r;
                    csr_data       <= alu_result;
                    csr_read_addr  <= '0;
                    out_valid      <= 1'b1;
                    state          <= ST_RESP;
                end
                ST_E_EPC: begin
                    csr_write      <= 1'b1;
                    csr_write_addr <= CSR_DIG'(CSR_MEPC);
                    csr_data       <= pc_r;
                    csr_read_addr  <= CSR_DIG'(CSR_MSTATUS);
                    state          <= ST_E_STAT;
                end
                ST_E_STAT: begin
                    csr_write      <= 1'b1;
                    csr_write_addr <= CSR_DIG'(CSR_MSTATUS);
                    csr_data       <= alu_result;
                    csr_read_addr  <= CSR_DIG'(CSR_MTVEC);
                    state          <= ST_E_VEC;
                end
                ST_E_VEC: begin
                    out_pc        <= csr_out;
                    out_redirect  <= 1'b1;
                    out_valid     <= 1'b1;
                    csr_read_addr <= '0;
                    state         <= ST_RESP;
                end
                ST_R_EPC: begin
                    out_pc        <= csr_out;
                    csr_read_addr <= CSR_DIG'(CSR_MSTATUS);
                    state         <= ST_R_STAT;
                end
                ST_R_STAT: begin
                    csr_write      <= 1'b1;
                    csr_write_addr <= CSR_DIG'(CSR_MSTATUS);
                    csr_data       <= alu_result;
                    csr_read_addr  <= '0;
                    out_redirect   <= 1'b1;
                    out_valid      <= 1'b1;
                    state          <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid     <= 1'b0;
                    in_ready      <= 1'b1;
                    csr_read_addr <= '0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_csr_seq.sv
// Self-checking bench for the CSR/trap sequencer: a table of directed
// operations with hand-computed results, plus back-pressure and
// mid-sequence reset sequences. A small CSR file model answers reads.
module tb_ysyx_25040129_csr_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'b000;
    logic [11:0] in_addr = 12'h000;
    logic [31:0] in_src = 32'h0;
    logic        in_src_is_x0 = 1'b0;
    logic [31:0] in_pc = 32'h0;
    logic [11:0] csr_read_addr;
    logic [31:0] csr_out;
    logic        csr_write;
    logic [11:0] csr_write_addr;
    logic [31:0] csr_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rd;
    logic        out_redirect;
    logic [31:0] out_pc;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_25040129_csr_seq #(.CSR_DIG(12), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_src(in_src), .in_src_is_x0(in_src_is_x0),
        .in_pc(in_pc),
        .csr_read_addr(csr_read_addr), .csr_out(csr_out),
        .csr_write(csr_write), .csr_write_addr(csr_write_addr), .csr_data(csr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_redirect(out_redirect), .out_pc(out_pc), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // CSR file model: combinational read, write log and commit on posedge
    logic [31:0] csr_mem [0:4095];
    logic [11:0] wlog_a [0:255];
    logic [31:0] wlog_d [0:255];
    int          wtotal = 0;

    assign csr_out = csr_mem[csr_read_addr];

    always @(posedge clk) begin
        if (rst) begin
            csr_mem[12'h300] <= 32'h0000_1800;
            csr_mem[12'h305] <= 32'h0000_0000;
            csr_mem[12'h340] <= 32'h1234_5678;
            csr_mem[12'h341] <= 32'h0000_0000;
            csr_mem[12'h000] <= 32'h0000_0000;
        end else if (csr_write) begin
            csr_mem[csr_write_addr]  <= csr_data;
            wlog_a[wtotal[7:0]]      <= csr_write_addr;
            wlog_d[wtotal[7:0]]      <= csr_data;
            wtotal                   <= wtotal + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        logic        x0;
        logic [31:0] pc;
        int          nw;
        logic [11:0] w0a;
        logic [31:0] w0d;
        logic [11:0] w1a;
        logic [31:0] w1d;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] opc;
        logic        err;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] src, input logic x0, input logic [31:0] pc,
                                input int nw, input logic [11:0] w0a, input logic [31:0] w0d,
                                input logic [11:0] w1a, input logic [31:0] w1d,
                                input logic [31:0] rd, input logic redir, input logic [31:0] opc,
                                input logic err, input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.src = src; v.x0 = x0; v.pc = pc;
        v.nw = nw; v.w0a = w0a; v.w0d = w0d; v.w1a = w1a; v.w1d = w1d;
        v.rd = rd; v.redir = redir; v.opc = opc; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Issue one request, wait for the response, hold it for 'hold' cycles, retire it
    task automatic run_vec(input string tag, input vec_t v, input int hold);
        int base;
        int lat;
        base = wtotal;
        chk({tag, " in_ready_idle"}, {31'h0, in_ready}, 32'h1);
        in_op = v.op; in_addr = v.addr; in_src = v.src;
        in_src_is_x0 = v.x0; in_pc = v.pc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " in_ready_busy"}, {31'h0, in_ready}, 32'h0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " rd"}, out_rd, v.rd);
        chk({tag, " redirect"}, {31'h0, out_redirect}, {31'h0, v.redir});
        chk({tag, " pc"}, out_pc, v.opc);
        chk({tag, " err"}, {31'h0, out_err}, {31'h0, v.err});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, {31'h0, out_valid}, 32'h1);
            chk({tag, " hold_rd"}, out_rd, v.rd);
            chk({tag, " hold_in_ready"}, {31'h0, in_ready}, 32'h0);
            chk({tag, " hold_no_write"}, {31'h0, csr_write}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, {31'h0, out_valid}, 32'h0);
        chk({tag, " ready_back"}, {31'h0, in_ready}, 32'h1);
        chk({tag, " idle_raddr"}, {20'h0, csr_read_addr}, 32'h0);
        chk({tag, " nwrites"}, wtotal - base, v.nw);
        if (v.nw >= 1) begin
            chk({tag, " w0_addr"}, {20'h0, wlog_a[base[7:0]]}, {20'h0, v.w0a});
            chk({tag, " w0_data"}, wlog_d[base[7:0]], v.w0d);
        end
        if (v.nw >= 2) begin
            chk({tag, " w1_addr"}, {20'h0, wlog_a[8'(base + 1)]}, {20'h0, v.w1a});
            chk({tag, " w1_data"}, wlog_d[8'(base + 1)], v.w1d);
        end
    endtask

    vec_t vecs [0:17];
    vec_t tmp;

    initial begin
        // op, addr, src, x0, pc, nw, w0a, w0d, w1a, w1d, rd, redir, pc, err, lat
        vecs[0]  = mk(3'b000, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 1, 12'h305, 32'h8000_0100, 12'h0, 32'h0, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 2);
        vecs[1]  = mk(3'b001, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 1, 12'h300, 32'h0000_1808, 12'h0, 32'h0, 32'h0000_1800, 1'b0, 32'h0, 1'b0, 2);
        vecs[2]  = mk(3'b010, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 1, 12'h300, 32'h0000_1800, 12'h0, 32'h0, 32'h0000_1808, 1'b0, 32'h0, 1'b0, 2);
        vecs[3]  = mk(3'b001, 12'h340, 32'h0000_0000, 1'b1, 32'h0, 0, 12'h0,   32'h0,         12'h0, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 2);
        vecs[4]  = mk(3'b010, 12'h340, 32'hFFFF_FFFF, 1'b1, 32'h0, 0, 12'h0,   32'h0,         12'h0, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 2);
        vecs[5]  = mk(3'b000, 12'h340, 32'h0000_0000, 1'b1, 32'h0, 1, 12'h340, 32'h0000_0000, 12'h0, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 2);
        vecs[6]  = mk(3'b000, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 1, 12'h300, 32'h0000_0008, 12'h0, 32'h0, 32'h0000_1800, 1'b0, 32'h0, 1'b0, 2);
        vecs[7]  = mk(3'b000, 12'h305, 32'h8000_0200, 1'b0, 32'h0, 1, 12'h305, 32'h8000_0200, 12'h0, 32'h0, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 2);
        vecs[8]  = mk(3'b011, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 2, 12'h341, 32'h8000_0040, 12'h300, 32'h0000_1880, 32'h0, 1'b1, 32'h8000_0200, 1'b0, 4);
        vecs[9]  = mk(3'b000, 12'h341, 32'h8000_0044, 1'b0, 32'h0, 1, 12'h341, 32'h8000_0044, 12'h0, 32'h0, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 2);
        vecs[10] = mk(3'b100, 12'h000, 32'h0, 1'b0, 32'h0, 1, 12'h300, 32'h0000_1888, 12'h0, 32'h0, 32'h0, 1'b1, 32'h8000_0044, 1'b0, 3);
        vecs[11] = mk(3'b101, 12'h300, 32'h1, 1'b0, 32'h0, 0, 12'h0, 32'h0, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        vecs[12] = mk(3'b111, 12'h305, 32'h0, 1'b0, 32'h0, 0, 12'h0, 32'h0, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        vecs[13] = mk(3'b011, 12'h000, 32'h0, 1'b0, 32'h8000_0100, 2, 12'h341, 32'h8000_0100, 12'h300, 32'h0000_1880, 32'h0, 1'b1, 32'h8000_0200, 1'b0, 4);
        vecs[14] = mk(3'b000, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 1, 12'h300, 32'h0000_0008, 12'h0, 32'h0, 32'h0000_1880, 1'b0, 32'h0, 1'b0, 2);
        vecs[15] = mk(3'b100, 12'h000, 32'h0, 1'b0, 32'h0, 1, 12'h300, 32'h0000_1880, 12'h0, 32'h0, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 3);
        vecs[16] = mk(3'b010, 12'h300, 32'h0000_1800, 1'b0, 32'h0, 1, 12'h300, 32'h0000_0080, 12'h0, 32'h0, 32'h0000_1880, 1'b0, 32'h0, 1'b0, 2);
        vecs[17] = mk(3'b001, 12'h305, 32'h0000_000F, 1'b0, 32'h0, 1, 12'h305, 32'h8000_020F, 12'h0, 32'h0, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset csr_write", {31'h0, csr_write}, 32'h0);
        chk("reset read_addr", {20'h0, csr_read_addr}, 32'h0);
        chk("reset out_pc", out_pc, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Back-pressure: response held for 5 cycles must stay stable
        tmp = mk(3'b001, 12'h305, 32'h0, 1'b1, 32'h0, 0, 12'h0, 32'h0, 12'h0, 32'h0, 32'h8000_020F, 1'b0, 32'h0, 1'b0, 2);
        run_vec("hold5", tmp, 5);

        // Reset pulse in E_STAT abandons the ECALL
        in_op = 3'b011; in_pc = 32'h8000_0300; in_addr = 12'h000; in_src = 32'h0;
        in_src_is_x0 = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("estat csr_write", {31'h0, csr_write}, 32'h1);
        chk("estat write_addr", {20'h0, csr_write_addr}, 32'h341);
        chk("estat read_addr", {20'h0, csr_read_addr}, 32'h300);
        rst = 1'b1;
        #1;
        chk("rstpulse csr_write", {31'h0, csr_write}, 32'h0);
        chk("rstpulse in_ready", {31'h0, in_ready}, 32'h1);
        chk("rstpulse out_valid", {31'h0, out_valid}, 32'h0);
        chk("rstpulse read_addr", {20'h0, csr_read_addr}, 32'h0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        tmp = mk(3'b000, 12'h340, 32'hCAFE_F00D, 1'b0, 32'h0, 1, 12'h340, 32'hCAFE_F00D, 12'h0, 32'h0, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 2);
        run_vec("post_rst_rw", tmp, 0);
        tmp = mk(3'b001, 12'h340, 32'h0, 1'b1, 32'h0, 0, 12'h0, 32'h0, 12'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 2);
        run_vec("post_rst_rs", tmp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
